// File: rtl/ft_pkg.sv
// Shared types and debug-map constants for the lockstep fault-tolerance controller.
package ft_pkg;
    typedef enum logic [2:0] {RUN, HALT, RESTORE, NPC, RESUME, ERROR} ft_state_e;

    localparam logic [14:0] DBG_GPR_BASE = 15'h0400;
    localparam logic [14:0] DBG_NPC      = 15'h2000;
endpackage

// File: rtl/ft_voter.sv
// Combinational majority voter over the per-core regfile write tuples {we, addr, data}.
module ft_voter #(
    parameter int N_CORES = 3,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5
) (
    input  logic [N_CORES-1:0]             we_i,
    input  logic [N_CORES-1:0][ADDR_W-1:0] waddr_i,
    input  logic [N_CORES-1:0][DATA_W-1:0] wdata_i,
    output logic                           agree_o,
    output logic                           voted_we_o,
    output logic [ADDR_W-1:0]              voted_addr_o,
    output logic [DATA_W-1:0]              voted_data_o,
    output logic [N_CORES-1:0]             outlier_o,
    output logic                           no_majority_o
);
    localparam int IDX_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;

    logic [N_CORES-1:0][N_CORES-1:0] eq;
    logic [IDX_W-1:0]                win;
    int                              cnt;

    // Two idle cores match whatever their addr/data lanes carry.
    always_comb begin
        eq = '0;
        for (int i = 0; i < N_CORES; i++) begin
            for (int j = 0; j < N_CORES; j++) begin
                eq[i][j] = (!we_i[i] && !we_i[j]) ||
                           (we_i[i] == we_i[j] && waddr_i[i] == waddr_i[j] &&
                            wdata_i[i] == wdata_i[j]);
            end
        end
    end

    // A strict majority means both cores under DMR and any two under TMR.
    always_comb begin
        agree_o = 1'b0;
        win     = '0;
        cnt     = 0;
        for (int i = N_CORES - 1; i >= 0; i--) begin
            cnt = 0;
            for (int j = 0; j < N_CORES; j++) begin
                if (eq[i][j]) cnt++;
            end
            if (2 * cnt > N_CORES) begin
                agree_o = 1'b1;
                win     = IDX_W'(i);
            end
        end
    end

    always_comb begin
        outlier_o = '0;
        for (int k = 0; k < N_CORES; k++) begin
            outlier_o[k] = agree_o && !eq[win][k];
        end
    end

    assign voted_we_o    = we_i[win];
    assign voted_addr_o  = waddr_i[win];
    assign voted_data_o  = wdata_i[win];
    assign no_majority_o = !agree_o;
endmodule

// File: rtl/ft_lockstep_ctrl.sv
// Lockstep controller: votes replicated regfile writes into a shadow regfile and, on
// divergence, halts the cores and rewrites every GPR plus the NPC from that checkpoint.
module ft_lockstep_ctrl
    import ft_pkg::*;
#(
    parameter int N_CORES      = 3,
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter int HALT_TIMEOUT = 16,
    parameter int CNT_W        = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [N_CORES-1:0]          we_i,
    input  logic [N_CORES*ADDR_W-1:0]   waddr_i,
    input  logic [N_CORES*DATA_W-1:0]   wdata_i,
    input  logic [DATA_W-1:0]           pc_i,
    input  logic [N_CORES-1:0]          halted_i,
    output logic                        halt_o,
    output logic                        resume_o,
    output logic                        dbg_we_o,
    output logic [14:0]                 dbg_addr_o,
    output logic [DATA_W-1:0]           dbg_wdata_o,
    output logic                        busy_o,
    output logic                        err_o,
    output logic [N_CORES-1:0]          fault_core_o,
    output logic [CNT_W-1:0]            fault_cnt_o
);
    localparam int NREGS  = 2**ADDR_W;
    localparam int TMO_W  = $clog2(HALT_TIMEOUT) + 1;
    localparam bit IS_TMR = (N_CORES >= 3);

    ft_state_e state_q, state_d;

    logic [N_CORES-1:0][ADDR_W-1:0] waddr_v;
    logic [N_CORES-1:0][DATA_W-1:0] wdata_v;
    logic                           agree, v_we, no_maj;
    logic [ADDR_W-1:0]              v_addr;
    logic [DATA_W-1:0]              v_data;
    logic [N_CORES-1:0]             outlier;

    logic [NREGS-1:0][DATA_W-1:0]   shadow_q;
    logic [DATA_W-1:0]              ckpt_q;
    logic [TMO_W-1:0]               tmo_q;
    logic [ADDR_W-1:0]              idx_q;
    logic [N_CORES-1:0]             fault_core_q;
    logic [CNT_W-1:0]               fault_cnt_q;
    logic                           in_run, commit, mismatch, fatal;

    assign waddr_v = waddr_i;
    assign wdata_v = wdata_i;

    ft_voter #(.N_CORES(N_CORES), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_voter (
        .we_i         (we_i),
        .waddr_i      (waddr_v),
        .wdata_i      (wdata_v),
        .agree_o      (agree),
        .voted_we_o   (v_we),
        .voted_addr_o (v_addr),
        .voted_data_o (v_data),
        .outlier_o    (outlier),
        .no_majority_o(no_maj)
    );

    // A TMR outlier still commits the majority before recovery starts.
    assign in_run   = (state_q == RUN);
    assign commit   = in_run && agree && v_we && (v_addr != '0);
    assign mismatch = in_run && (IS_TMR ? (agree && (|outlier)) : no_maj);
    assign fatal    = in_run && IS_TMR && no_maj;

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= RUN;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (fatal)         state_d = ERROR;
                     else if (mismatch) state_d = HALT;
            HALT:    if (&halted_i)     state_d = RESTORE;
                     else if (tmo_q == TMO_W'(HALT_TIMEOUT - 1)) state_d = ERROR;
            RESTORE: if (&idx_q)        state_d = NPC;
            NPC:                        state_d = RESUME;
            RESUME:                     state_d = RUN;
            ERROR:                      state_d = ERROR;
            default:                    state_d = RUN;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shadow_q     <= '0;
            ckpt_q       <= '0;
            tmo_q        <= '0;
            idx_q        <= ADDR_W'(1);
            fault_core_q <= '0;
            fault_cnt_q  <= '0;
        end else begin
            if (commit) begin
                shadow_q[v_addr] <= v_data;
                ckpt_q           <= pc_i;
            end
            if (IS_TMR && mismatch) fault_core_q <= fault_core_q | outlier;
            if (mismatch && !(&fault_cnt_q)) fault_cnt_q <= fault_cnt_q + 1'b1;
            tmo_q <= (state_q == HALT)    ? tmo_q + 1'b1 : '0;
            idx_q <= (state_q == RESTORE) ? idx_q + 1'b1 : ADDR_W'(1);
        end
    end

    always_comb begin
        halt_o      = 1'b0;
        resume_o    = 1'b0;
        dbg_we_o    = 1'b0;
        dbg_addr_o  = '0;
        dbg_wdata_o = '0;
        busy_o      = 1'b0;
        err_o       = 1'b0;
        case (state_q)
            HALT: begin
                halt_o = 1'b1;
                busy_o = 1'b1;
            end
            RESTORE: begin
                halt_o      = 1'b1;
                busy_o      = 1'b1;
                dbg_we_o    = 1'b1;
                dbg_addr_o  = DBG_GPR_BASE + (15'(idx_q) << 2);
                dbg_wdata_o = shadow_q[idx_q];
            end
            NPC: begin
                halt_o      = 1'b1;
                busy_o      = 1'b1;
                dbg_we_o    = 1'b1;
                dbg_addr_o  = DBG_NPC;
                dbg_wdata_o = ckpt_q;
            end
            RESUME: begin
                resume_o = 1'b1;
                busy_o   = 1'b1;
            end
            ERROR: begin
                halt_o = 1'b1;
                err_o  = 1'b1;
            end
            default: ;
        endcase
    end

    assign fault_core_o = fault_core_q;
    assign fault_cnt_o  = fault_cnt_q;
endmodule
